pwm_deadtime_gen: RTL

- Downstream consumer of the triangle-carrier lookup stage.
- Compares a signed modulating reference against the signed 10-bit triangle carrier to form a naturally sampled PWM decision.
- Drives complementary high-side and low-side gate signals with programmable dead time and an enable gate.
- Reference and dead time are double-buffered and update only on a carrier-period sync strobe from the phase accumulator.

---
 rtl/pwm_deadtime_gen_if.sv | 24 ++
 rtl/pwm_deadtime_gen.sv | 102 ++++++++++
 2 files changed

// File: rtl/pwm_deadtime_gen_if.sv
// rtl/pwm_deadtime_gen_if.sv - carrier/reference inputs and gate outputs of the dead-time PWM stage
interface pwm_deadtime_gen_if #(
  parameter int DT_W = 8
);
  logic                   EN;
  logic                   SYNC;
  logic signed [9:0]      CARRIER;
  logic signed [9:0]      MOD_REF;
  logic        [DT_W-1:0] DEAD_TIME;
  logic                   CMP_RAW;
  logic                   PWM_H;
  logic                   PWM_L;
  logic                   DT_BUSY;

  modport master (
    output EN, SYNC, CARRIER, MOD_REF, DEAD_TIME,
    input  CMP_RAW, PWM_H, PWM_L, DT_BUSY
  );

  modport slave (
    input  EN, SYNC, CARRIER, MOD_REF, DEAD_TIME,
    output CMP_RAW, PWM_H, PWM_L, DT_BUSY
  );
endinterface

// File: rtl/pwm_deadtime_gen.sv
// rtl/pwm_deadtime_gen.sv - naturally sampled PWM with complementary gates and dead time
module pwm_deadtime_gen #(
  parameter int CARRIER_MAX = 364,
  parameter int DT_DEFAULT  = 8,
  parameter int DT_W        = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  pwm_deadtime_gen_if.slave bus
);
  localparam logic signed [9:0] POS_MAX = 10'(CARRIER_MAX);
  localparam logic signed [9:0] NEG_MAX = 10'(-CARRIER_MAX);

  typedef enum logic [2:0] {OFF, DT_TO_H, H_ON, DT_TO_L, L_ON} state_t;

  state_t            state, state_nxt;
  logic [DT_W-1:0]   cnt, cnt_nxt, dt_load;
  logic [DT_W-1:0]   dt_act;
  logic signed [9:0] ref_act, ref_clamped;
  logic              cmp_raw, pwm_h, pwm_l, dt_busy;

  always_comb begin
    ref_clamped = bus.MOD_REF;
    if (bus.MOD_REF > POS_MAX)
      ref_clamped = POS_MAX;
    else if (bus.MOD_REF < NEG_MAX)
      ref_clamped = NEG_MAX;
  end

  // A zero dead time still yields one both-off cycle so the gates never switch directly.
  assign dt_load = (dt_act == '0) ? DT_W'(1) : dt_act;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!bus.EN) begin
      state_nxt = OFF;
      cnt_nxt   = '0;
    end else begin
      case (state)
        OFF: begin
          state_nxt = cmp_raw ? DT_TO_H : DT_TO_L;
          cnt_nxt   = dt_load;
        end
        DT_TO_H, DT_TO_L: begin
          if (cnt <= DT_W'(1)) begin
            state_nxt = cmp_raw ? H_ON : L_ON;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - DT_W'(1);
          end
        end
        H_ON: begin
          if (!cmp_raw) begin
            state_nxt = DT_TO_L;
            cnt_nxt   = dt_load;
          end
        end
        L_ON: begin
          if (cmp_raw) begin
            state_nxt = DT_TO_H;
            cnt_nxt   = dt_load;
          end
        end
        default: begin
          state_nxt = OFF;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Gate outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ref_act <= '0;
      dt_act  <= DT_W'(DT_DEFAULT);
      cmp_raw <= 1'b0;
      state   <= OFF;
      cnt     <= '0;
      pwm_h   <= 1'b0;
      pwm_l   <= 1'b0;
      dt_busy <= 1'b0;
    end else begin
      if (bus.SYNC) begin
        ref_act <= ref_clamped;
        dt_act  <= bus.DEAD_TIME;
      end
      cmp_raw <= (ref_act > bus.CARRIER);
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pwm_h   <= (state_nxt == H_ON);
      pwm_l   <= (state_nxt == L_ON);
      dt_busy <= (state_nxt == DT_TO_H) || (state_nxt == DT_TO_L);
    end
  end

  assign bus.CMP_RAW = cmp_raw;
  assign bus.PWM_H   = pwm_h;
  assign bus.PWM_L   = pwm_l;
  assign bus.DT_BUSY = dt_busy;
endmodule
